// File: rtl/diff_ser_pkg.sv
// Shared types and constants for the differential lane serializer.
// Optional macro: DIFF_SER_POL_INV_EN (per-output polarity inversion).
package diff_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic D_IDLE    = 1'b0;

  function automatic int bit_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/diff_ser_tick_gen.sv
// Half-period counter: tick marks the last cycle of a half-period.
// Counts up to div and wraps; load restarts a half-period.
module diff_ser_tick_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick = (cnt_q == div);

  // Next count: restart on load or at the end of a half-period.
  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (load || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/diff_lane_serializer.sv
// Multi-lane MSB-first serializer with shared sclk and cs_n strobe.
// Optional macro: DIFF_SER_POL_INV_EN adds pol_inv and an output XOR stage.
module diff_lane_serializer
  import diff_ser_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int WORD_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_WIDTH-1:0]        clk_div,
  input  logic [LANES*WORD_WIDTH-1:0] s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        busy,
  output logic                        sclk_out,
  output logic                        cs_n_out,
  output logic [LANES-1:0]            d_out
`ifdef DIFF_SER_POL_INV_EN
  ,
  input  logic [LANES+1:0]            pol_inv
`endif
);

  localparam int BCW = bit_cnt_w(WORD_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_WIDTH - 1);

  state_e state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [LANES-1:0][WORD_WIDTH-2:0] sh_q, sh_d;
  logic [LANES-1:0] d_q, d_d;
  logic sclk_q, sclk_d;
  logic cs_q, cs_d;
  logic load;
  logic tick;

  assign s_ready = (state_q == IDLE) && !rst;
  assign busy    = (state_q != IDLE);

  diff_ser_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .load(load),
    .div (div_q),
    .tick(tick)
  );

  // Next-state and next-output logic; every output comes from a flop.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    d_d     = d_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          load    = 1'b1;
          state_d = SETUP;
          div_d   = clk_div;
          bit_d   = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          for (int i = 0; i < LANES; i++) begin
            sh_d[i] = s_data[i*WORD_WIDTH +: WORD_WIDTH-1];
            d_d[i]  = s_data[i*WORD_WIDTH + WORD_WIDTH-1];
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d = GAP;
            cs_d    = CS_IDLE;
            d_d     = {LANES{D_IDLE}};
          end else begin
            state_d = LOW;
            bit_d   = bit_q + BCW'(1);
            for (int i = 0; i < LANES; i++) begin
              d_d[i]  = sh_q[i][WORD_WIDTH-2];
              sh_d[i] = sh_q[i] << 1;
            end
          end
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and line registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      d_q     <= {LANES{D_IDLE}};
      sclk_q  <= SCLK_IDLE;
      cs_q    <= CS_IDLE;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
    end
  end

`ifdef DIFF_SER_POL_INV_EN
  logic [LANES+1:0] o_q;

  // Extra stage applying board polarity swaps to every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= {CS_IDLE, SCLK_IDLE, {LANES{D_IDLE}}} ^ pol_inv;
    end else begin
      o_q <= {cs_q, sclk_q, d_q} ^ pol_inv;
    end
  end

  assign cs_n_out = o_q[LANES+1];
  assign sclk_out = o_q[LANES];
  assign d_out    = o_q[LANES-1:0];
`else
  assign cs_n_out = cs_q;
  assign sclk_out = sclk_q;
  assign d_out    = d_q;
`endif

endmodule
